// File: rtl/acc_pkg.sv
// Shared definitions for the accelerator BIU blocks: FSM state type and default sizing.
package acc_pkg;

    localparam int RSP_FIFO_DEPTH_DEF = 4;
    localparam int CNT_W_DEF          = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } imap_state_e;

endpackage

// File: rtl/imap_biu_if.sv
// Arbiter read channel and line-buffer channel of the input-map BIU.
interface imap_biu_if;

    logic        imap_biu2arb_req;
    logic [31:0] imap_biu2arb_addr;
    logic        imap_biu2arb_vld;
    logic        imap_biu2arb_rdy;
    logic [31:0] arb2imap_biu_data;
    logic        arb2imap_biu_vld;
    logic        arb2imap_biu_rdy;
    logic [31:0] imap_biu2lbuf_data;
    logic        imap_biu2lbuf_vld;
    logic        imap_biu2lbuf_rdy;

    modport master (
        output imap_biu2arb_req, imap_biu2arb_addr, imap_biu2arb_vld,
               arb2imap_biu_rdy, imap_biu2lbuf_data, imap_biu2lbuf_vld,
        input  imap_biu2arb_rdy, arb2imap_biu_data, arb2imap_biu_vld,
               imap_biu2lbuf_rdy
    );

    modport slave (
        input  imap_biu2arb_req, imap_biu2arb_addr, imap_biu2arb_vld,
               arb2imap_biu_rdy, imap_biu2lbuf_data, imap_biu2lbuf_vld,
        output imap_biu2arb_rdy, arb2imap_biu_data, arb2imap_biu_vld,
               imap_biu2lbuf_rdy
    );

endinterface

// File: rtl/imap_rsp_fifo.sv
// Response buffer: synchronous FIFO with registered storage and an occupancy count.
module imap_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/imap_biu.sv
// Input-map bus interface: streams in_ch*map_size words from memory into the line buffer.
// Optional IMAP_BIU_PERF_CNT_EN adds the stall_cnt performance counter port.
module imap_biu
    import acc_pkg::*;
#(
    parameter int RSP_FIFO_DEPTH = RSP_FIFO_DEPTH_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_ch,
    input  logic [15:0] map_size,
    input  logic [31:0] imap_base_addr,
    input  logic        conv_start,
    imap_biu_if.master  bus,
    output logic        imap_done
`ifdef IMAP_BIU_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int CW = $clog2(RSP_FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_FIFO_DEPTH);

    imap_state_e    state;
    logic [CNT_W-1:0] total, issued, delivered;
    logic [CW-1:0]  outstanding, fifo_count;
    logic           fifo_empty, req_q;
    logic [31:0]    fifo_head;
    logic           has_credit, cmd_vld, cmd_hs, rsp_hs, lb_hs;

    // Reads in flight plus words already buffered must never exceed the FIFO depth.
    assign has_credit = (outstanding + fifo_count) < DEPTH_C;
    assign cmd_vld    = (state == READ) && (issued < total) && has_credit;
    assign cmd_hs     = cmd_vld && bus.imap_biu2arb_rdy;
    assign rsp_hs     = bus.arb2imap_biu_vld && bus.arb2imap_biu_rdy;
    assign lb_hs      = bus.imap_biu2lbuf_vld && bus.imap_biu2lbuf_rdy;

    assign bus.imap_biu2arb_req   = req_q;
    assign bus.imap_biu2arb_vld   = cmd_vld;
    assign bus.imap_biu2arb_addr  = cmd_vld ? imap_base_addr + 32'(issued) : 32'd0;
    assign bus.arb2imap_biu_rdy   = (state != IDLE);
    assign bus.imap_biu2lbuf_vld  = !fifo_empty;
    assign bus.imap_biu2lbuf_data = fifo_head;

    imap_rsp_fifo #(.DEPTH(RSP_FIFO_DEPTH), .W(32)) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_hs),
        .push_data (bus.arb2imap_biu_data),
        .pop       (lb_hs),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            total       <= '0;
            issued      <= '0;
            delivered   <= '0;
            outstanding <= '0;
            req_q       <= 1'b0;
            imap_done   <= 1'b0;
        end else begin
            imap_done <= 1'b0;
            if (cmd_hs) issued <= issued + 1'b1;
            if (lb_hs)  delivered <= delivered + 1'b1;
            case ({cmd_hs, rsp_hs})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase
            case (state)
                IDLE: if (conv_start) begin
                    total     <= CNT_W'(in_ch) * CNT_W'(map_size);
                    issued    <= '0;
                    delivered <= '0;
                    if (in_ch == 8'd0 || map_size == 16'd0) begin
                        state     <= DONE;
                        imap_done <= 1'b1;
                    end else begin
                        state <= READ;
                        req_q <= 1'b1;
                    end
                end
                READ: if (cmd_hs && (issued + 1'b1) == total) state <= DRAIN;
                DRAIN: if (lb_hs && (delivered + 1'b1) == total) begin
                    state     <= DONE;
                    req_q     <= 1'b0;
                    imap_done <= 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IMAP_BIU_PERF_CNT_EN
    logic stall;
    assign stall = (cmd_vld && !bus.imap_biu2arb_rdy) || (state == READ && !has_credit);

    always_ff @(posedge clk) begin
        if (!rst_n)                           stall_cnt <= '0;
        else if (state == IDLE && conv_start) stall_cnt <= '0;
        else if (stall && stall_cnt != '1)    stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_imap_biu.sv
// Bench for imap_biu: arbiter/memory and line-buffer models driven cycle by cycle with random stalls.
module tb_imap_biu;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_ch = '0;
    logic [15:0] map_size = '0;
    logic [31:0] imap_base_addr = '0;
    logic        conv_start = 1'b0;
    logic        imap_done;
`ifdef IMAP_BIU_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;

    imap_biu_if bus();

    imap_biu #(.RSP_FIFO_DEPTH(DEPTH), .CNT_W(24)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_ch          (in_ch),
        .map_size       (map_size),
        .imap_base_addr (imap_base_addr),
        .conv_start     (conv_start),
        .bus            (bus),
        .imap_done      (imap_done)
`ifdef IMAP_BIU_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory contents seen through the arbiter.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic drive_idle();
        bus.imap_biu2arb_rdy  = 1'b0;
        bus.arb2imap_biu_vld  = 1'b0;
        bus.arb2imap_biu_data = '0;
        bus.imap_biu2lbuf_rdy = 1'b0;
        conv_start            = 1'b0;
    endtask

    // One conv_start transfer against the reference: addresses must be base+0..total-1
    // in order, delivered words must be mem_word of those addresses in order.
    task automatic xfer(input logic [7:0] ch, input logic [15:0] ms, input logic [31:0] base,
                        input int p_arb, input int p_lb, input int lat_min, input int lat_max,
                        input int lb_hold, input bit start_in_drain, input int rst_at,
                        input string tag);
        int total, iss, rcv, dlv, dones, cyc, done_cyc;
        logic [31:0] q_addr[$];
        int          q_t[$];
        bit prev_stall, exp_vld, pulsed, fin, aborted, cmd, rsp, lb;
        logic [31:0] prev_addr, exp_a, exp_d;
        total = int'(ch) * int'(ms);
        iss = 0; rcv = 0; dlv = 0; dones = 0; cyc = 0; done_cyc = 0;
        prev_stall = 0; exp_vld = 0; pulsed = 0; fin = 0; aborted = 0; prev_addr = '0;
        @(negedge clk);
        in_ch = ch; map_size = ms; imap_base_addr = base;
        drive_idle();
        conv_start = 1'b1;
        @(negedge clk);
        conv_start = 1'b0;
        while (cyc < 2000) begin
            if (rst_at > 0 && (iss - rcv) == rst_at) begin
                rst_n = 1'b0;
                drive_idle();
                @(posedge clk); #1;
                n_chk++; if (bus.imap_biu2arb_req !== 1'b0) begin n_fail++; $display("FAIL %s rst_req got %b want 0", tag, bus.imap_biu2arb_req); end
                n_chk++; if (bus.imap_biu2arb_vld !== 1'b0) begin n_fail++; $display("FAIL %s rst_vld got %b want 0", tag, bus.imap_biu2arb_vld); end
                n_chk++; if (bus.imap_biu2arb_addr !== 32'd0) begin n_fail++; $display("FAIL %s rst_addr got %h want 0", tag, bus.imap_biu2arb_addr); end
                n_chk++; if (bus.arb2imap_biu_rdy !== 1'b0) begin n_fail++; $display("FAIL %s rst_rsp_rdy got %b want 0", tag, bus.arb2imap_biu_rdy); end
                n_chk++; if (bus.imap_biu2lbuf_vld !== 1'b0) begin n_fail++; $display("FAIL %s rst_lbuf_vld got %b want 0", tag, bus.imap_biu2lbuf_vld); end
                n_chk++; if (bus.imap_biu2lbuf_data !== 32'd0) begin n_fail++; $display("FAIL %s rst_lbuf_data got %h want 0", tag, bus.imap_biu2lbuf_data); end
                n_chk++; if (imap_done !== 1'b0) begin n_fail++; $display("FAIL %s rst_done got %b want 0", tag, imap_done); end
                @(negedge clk);
                rst_n = 1'b1;
                aborted = 1;
                break;
            end
            bus.imap_biu2arb_rdy  = ($urandom_range(99) < p_arb);
            bus.imap_biu2lbuf_rdy = (cyc >= lb_hold) && ($urandom_range(99) < p_lb);
            if (q_addr.size() > 0 && cyc >= q_t[0]) begin
                bus.arb2imap_biu_vld  = 1'b1;
                bus.arb2imap_biu_data = mem_word(q_addr[0]);
            end else begin
                bus.arb2imap_biu_vld  = 1'b0;
                bus.arb2imap_biu_data = '0;
            end
            conv_start = 1'b0;
            if (start_in_drain && !pulsed && total > 0 && iss == total && dones == 0) begin
                conv_start = 1'b1;
                in_ch      = 8'd7;
                pulsed     = 1;
            end
            #1;
            cmd = bus.imap_biu2arb_vld && bus.imap_biu2arb_rdy;
            rsp = bus.arb2imap_biu_vld && bus.arb2imap_biu_rdy;
            lb  = bus.imap_biu2lbuf_vld && bus.imap_biu2lbuf_rdy;

            if (prev_stall) begin
                n_chk++;
                if (bus.imap_biu2arb_vld !== 1'b1 || bus.imap_biu2arb_addr !== prev_addr) begin
                    n_fail++;
                    $display("FAIL %s hold got vld=%b addr=%h want vld=1 addr=%h", tag, bus.imap_biu2arb_vld, bus.imap_biu2arb_addr, prev_addr);
                end
            end
            if (exp_vld) begin
                n_chk++;
                if (bus.imap_biu2lbuf_vld !== 1'b1) begin n_fail++; $display("FAIL %s lbuf_latency got vld=%b want 1", tag, bus.imap_biu2lbuf_vld); end
            end
            n_chk++;
            if (iss - dlv > DEPTH) begin n_fail++; $display("FAIL %s credit got %0d in flight want <= %0d", tag, iss - dlv, DEPTH); end
            if (total == 0) begin
                n_chk++;
                if (bus.imap_biu2arb_req !== 1'b0 || bus.imap_biu2arb_vld !== 1'b0) begin
                    n_fail++; $display("FAIL %s zero_req got req=%b vld=%b want 0 0", tag, bus.imap_biu2arb_req, bus.imap_biu2arb_vld);
                end
            end else if (dones == 0 && imap_done !== 1'b1) begin
                n_chk++;
                if (bus.imap_biu2arb_req !== 1'b1) begin n_fail++; $display("FAIL %s req_hold got %b want 1 at cyc %0d", tag, bus.imap_biu2arb_req, cyc); end
            end
            if (imap_done === 1'b1) begin
                dones++;
                done_cyc = cyc;
                n_chk++;
                if (dlv != total) begin n_fail++; $display("FAIL %s done_early got %0d delivered want %0d", tag, dlv, total); end
                if (total == 0) begin
                    n_chk++;
                    if (cyc != 0) begin n_fail++; $display("FAIL %s zero_done_cyc got %0d want 0", tag, cyc); end
                end
            end
            if (cmd) begin
                exp_a = base + 32'(iss);
                n_chk++;
                if (bus.imap_biu2arb_addr !== exp_a) begin n_fail++; $display("FAIL %s addr got %h want %h", tag, bus.imap_biu2arb_addr, exp_a); end
                q_addr.push_back(bus.imap_biu2arb_addr);
                q_t.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
                iss++;
            end
            if (rsp) begin
                void'(q_addr.pop_front());
                void'(q_t.pop_front());
                rcv++;
            end
            exp_vld = rsp && (bus.imap_biu2lbuf_vld !== 1'b1);
            if (lb) begin
                exp_d = mem_word(base + 32'(dlv));
                n_chk++;
                if (bus.imap_biu2lbuf_data !== exp_d) begin n_fail++; $display("FAIL %s data[%0d] got %h want %h", tag, dlv, bus.imap_biu2lbuf_data, exp_d); end
                dlv++;
            end
            prev_stall = bus.imap_biu2arb_vld && !bus.imap_biu2arb_rdy;
            prev_addr  = bus.imap_biu2arb_addr;
            if (dones > 0 && cyc >= done_cyc + 2) begin fin = 1; break; end
            cyc++;
            @(negedge clk);
        end
        drive_idle();
        if (!aborted) begin
            n_chk++; if (!fin) begin n_fail++; $display("FAIL %s timeout got %0d delivered want %0d", tag, dlv, total); end
            n_chk++; if (dones != 1) begin n_fail++; $display("FAIL %s done_count got %0d want 1", tag, dones); end
            n_chk++; if (iss != total) begin n_fail++; $display("FAIL %s issued got %0d want %0d", tag, iss, total); end
            n_chk++; if (dlv != total) begin n_fail++; $display("FAIL %s delivered got %0d want %0d", tag, dlv, total); end
            n_chk++; if (bus.imap_biu2arb_req !== 1'b0) begin n_fail++; $display("FAIL %s req_end got %b want 0", tag, bus.imap_biu2arb_req); end
        end else begin
            n_chk++; if (rst_at <= 0) begin n_fail++; $display("FAIL %s unexpected abort got 1 want 0", tag); end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        imap_base_addr = 32'hDEAD_0000;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (bus.imap_biu2arb_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", bus.imap_biu2arb_req); end
        n_chk++; if (bus.imap_biu2arb_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b want 0", bus.imap_biu2arb_vld); end
        n_chk++; if (bus.imap_biu2arb_addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr got %h want 0", bus.imap_biu2arb_addr); end
        n_chk++; if (bus.arb2imap_biu_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_rdy got %b want 0", bus.arb2imap_biu_rdy); end
        n_chk++; if (bus.imap_biu2lbuf_vld !== 1'b0) begin n_fail++; $display("FAIL reset_lbuf_vld got %b want 0", bus.imap_biu2lbuf_vld); end
        n_chk++; if (bus.imap_biu2lbuf_data !== 32'd0) begin n_fail++; $display("FAIL reset_lbuf_data got %h want 0", bus.imap_biu2lbuf_data); end
        n_chk++; if (imap_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", imap_done); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        xfer(8'd2, 16'd3, 32'h0000_1000, 100, 100, 1, 1, 0, 1'b0, 0, "basic");
    endtask

    task automatic test_lbuf_stall();
        xfer(8'd3, 16'd4, 32'h0000_4000, 100, 100, 1, 1, 20, 1'b0, 0, "lbuf_stall");
    endtask

    task automatic test_arb_random();
        xfer(8'd1, 16'd8, 32'hFFFF_FFFC, 50, 70, 1, 3, 0, 1'b0, 0, "addr_wrap");
        for (int i = 0; i < 6; i++)
            xfer(8'($urandom_range(3, 1)), 16'($urandom_range(6, 1)), $urandom, 50, 70, 1, 3, 0, 1'b0, 0, "random");
    endtask

    task automatic test_zero_total();
        xfer(8'd0, 16'd5, 32'h0000_8000, 100, 100, 1, 1, 0, 1'b0, 0, "zero_ch");
    endtask

    task automatic test_reset_mid();
        xfer(8'd4, 16'd4, 32'h0000_2000, 100, 100, 6, 6, 0, 1'b0, 3, "reset_mid");
        xfer(8'd1, 16'd4, 32'h0000_2000, 100, 100, 1, 2, 0, 1'b0, 0, "restart");
    endtask

    task automatic test_start_in_drain();
        xfer(8'd2, 16'd4, 32'h0000_3000, 100, 40, 1, 2, 0, 1'b1, 0, "start_in_drain");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lbuf_stall();
        test_arb_random();
        test_zero_total();
        test_reset_mid();
        test_start_in_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imap_biu.md
IMAP_BIU -- requirements
Module: imap_biu

Interface
REQ-001 Parameter RSP_FIFO_DEPTH, default 4, is the depth of the response buffer and the maximum number of outstanding reads (power of two, 2..16).
REQ-002 Parameter CNT_W, default 24, is the width of the word counters.
REQ-003 Port clk, input, 1: the single clock for the whole block.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port in_ch, input, 8: number of input channels.
REQ-006 Port map_size, input, 16: words per channel.
REQ-007 Port imap_base_addr, input, 32: word address of the first input-map word.
REQ-008 Port conv_start, input, 1: one-cycle start pulse.
REQ-009 Port imap_biu2arb_req, output, 1: bus ownership request to the arbiter.
REQ-010 Port imap_biu2arb_addr, output, 32: read word address.
REQ-011 Port imap_biu2arb_vld / imap_biu2arb_rdy, output/input, 1 each: read-command handshake.
REQ-012 Port arb2imap_biu_data, input, 32: read response data.
REQ-013 Port arb2imap_biu_vld / arb2imap_biu_rdy, input/output, 1 each: response handshake.
REQ-014 Port imap_biu2lbuf_data, output, 32: data to the line buffer.
REQ-015 Port imap_biu2lbuf_vld / imap_biu2lbuf_rdy, output/input, 1 each: line-buffer handshake.
REQ-016 Port imap_done, output, 1: one-cycle pulse after the last word is accepted by the line buffer.

Function
REQ-017 On conv_start in IDLE, the block latches total = in_ch*map_size (CNT_W bits), clears both counters, sets imap_biu2arb_req = 1 and enters READ.
REQ-018 The FSM has the states IDLE, READ, DRAIN and DONE; conv_start is ignored outside IDLE.
REQ-019 In READ, imap_biu2arb_vld = 1 when issued < total and credits > 0, where credits = RSP_FIFO_DEPTH - outstanding - fifo_count.
REQ-020 The address is imap_base_addr + issued (32-bit wrap) and is held stable while vld=1 and rdy=0.
REQ-021 Each command handshake increments issued and outstanding; when issued reaches total the FSM enters DRAIN and drops vld.
REQ-022 arb2imap_biu_rdy = 1 whenever the FSM is not IDLE; the credit rule guarantees that a response never finds the FIFO full.
REQ-023 Each response handshake pushes the data into the FIFO and decrements outstanding.
REQ-024 A command and a response in the same cycle leave outstanding unchanged.
REQ-025 The FIFO head drives imap_biu2lbuf_data, and imap_biu2lbuf_vld = !fifo_empty.
REQ-026 Each line-buffer handshake pops the FIFO and increments delivered.
REQ-027 A simultaneous push and pop leaves fifo_count unchanged.
REQ-028 Latency: the first response word appears on imap_biu2lbuf_vld one cycle after the response handshake (registered FIFO output).
REQ-029 In DRAIN, when delivered reaches total, the FSM enters DONE, clears imap_biu2arb_req and pulses imap_done for one cycle, then returns to IDLE on the next cycle.
REQ-030 When total = 0, the FSM goes directly from IDLE to DONE: no command is issued, req stays 0 and imap_done pulses exactly once.
REQ-031 imap_biu2arb_req stays 1 throughout READ and DRAIN even while vld = 0.

Reset
REQ-032 With rst_n = 0 at a clock edge, the block enters IDLE and clears all counters and FIFO pointers.
REQ-033 The reset values of the outputs are: req = 0, imap_biu2arb_vld = 0, imap_biu2arb_addr = 0, arb2imap_biu_rdy = 0, imap_biu2lbuf_vld = 0, imap_biu2lbuf_data = 0, imap_done = 0.
REQ-034 A reset mid-transfer abandons all outstanding reads; the integration ensures that the arbiter is reset together with this block.

Configuration
REQ-035 With IMAP_BIU_PERF_CNT_EN defined, the block adds output port stall_cnt [31:0], which counts cycles with imap_biu2arb_vld = 1 and imap_biu2arb_rdy = 0 plus cycles with credits = 0 in READ; it clears on conv_start, saturates at all ones and resets to 0.
REQ-036 Without IMAP_BIU_PERF_CNT_EN, the stall_cnt port and its logic are absent and behaviour is otherwise identical.

Structure
REQ-037 The shared package acc_pkg holds the FSM state typedef (IDLE/READ/DRAIN/DONE), the default RSP_FIFO_DEPTH and CNT_W.
REQ-038 The response buffer is a single sub-module, imap_rsp_fifo (sync FIFO, registered output, count output); the FSM and counters stay in imap_biu.

Verification
REQ-039 in_ch=2, map_size=3, base=0x1000, arbiter and line buffer always ready -> addresses 0x1000..0x1005 in order, 6 words delivered in order, imap_done pulses once, then req=0.
REQ-040 Line buffer rdy=0 for 20 cycles, response latency 1, depth 4 -> no more than 4 reads outstanding plus buffered, no response lost, vld resumes once rdy rises.
REQ-041 imap_biu2arb_rdy toggled randomly -> addr and vld held stable while stalled, no duplicate or skipped address.
REQ-042 in_ch=0 -> no command issued, imap_done pulses one cycle after conv_start processing, req never rises.
REQ-043 rst_n asserted mid-READ with 3 reads outstanding -> all outputs return to their reset values on the next edge, and a new conv_start restarts from base.
REQ-044 conv_start pulsed during DRAIN -> ignored: total unchanged and exactly one imap_done pulse.
